// File: rtl/alu_if.sv
// Operand/result bundle between the divider control and its ALU datapath.
interface alu_if;
   logic [31:0] src1;
   logic [31:0] src2;
   logic [5:0]  funct;
   logic [31:0] result;
   logic        carry;

   modport master (output src1, output src2, output funct, input result, input carry);
   modport slave  (input src1, input src2, input funct, output result, output carry);
endinterface

// File: rtl/alu.sv
// Registered 32-bit unsigned ALU for the complete divider; carry doubles as SUB borrow.
// Optional shifter (SLL/SRL) is compiled in when ALU_SHIFT_EN is defined.
module alu (
   input  logic clk,
   input  logic rst_n,
   alu_if.slave bus
);

   localparam logic [5:0] FUNCT_ADD  = 6'b001001;
   localparam logic [5:0] FUNCT_SUB  = 6'b001010;
   localparam logic [5:0] FUNCT_AND  = 6'b100100;
   localparam logic [5:0] FUNCT_OR   = 6'b100101;
   localparam logic [5:0] FUNCT_SLTU = 6'b101010;
`ifdef ALU_SHIFT_EN
   localparam logic [5:0] FUNCT_SLL  = 6'b000000;
   localparam logic [5:0] FUNCT_SRL  = 6'b000010;
`endif

   logic [31:0] next_result;
   logic        next_carry;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      next_result = '0;
      next_carry  = 1'b0;
      case (bus.funct)
         FUNCT_ADD:  {next_carry, next_result} = {1'b0, bus.src1} + {1'b0, bus.src2};
         // Bit 32 of the 33-bit difference is set exactly when src1 < src2.
         FUNCT_SUB:  {next_carry, next_result} = {1'b0, bus.src1} - {1'b0, bus.src2};
         FUNCT_AND:  next_result = bus.src1 & bus.src2;
         FUNCT_OR:   next_result = bus.src1 | bus.src2;
         FUNCT_SLTU: next_result = {31'b0, bus.src1 < bus.src2};
`ifdef ALU_SHIFT_EN
         FUNCT_SLL:  next_result = bus.src1 << bus.src2[4:0];
         FUNCT_SRL:  next_result = bus.src1 >> bus.src2[4:0];
`endif
         default: begin
            next_result = '0;
            next_carry  = 1'b0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.result <= '0;
         bus.carry  <= 1'b0;
      end else begin
         bus.result <= next_result;
         bus.carry  <= next_carry;
      end
   end

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu; shift expectations follow ALU_SHIFT_EN.
module tb_alu;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   alu_if bus ();

   alu dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive one operation between edges, then sample 1 ns after the loading edge.
   task automatic op(input logic [31:0] a, input logic [31:0] b, input logic [5:0] f);
      @(negedge clk);
      bus.src1  = a;
      bus.src2  = b;
      bus.funct = f;
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      rst_n     = 1'b0;
      bus.src1  = 32'h0;
      bus.src2  = 32'h0;
      bus.funct = 6'b001001;

      #1;
      check("reset_result", bus.result, 32'h0);
      check("reset_carry", {31'b0, bus.carry}, 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      op(32'h5, 32'h4, 6'b001010);
      check("sub_5_4_result", bus.result, 32'h00000001);
      check("sub_5_4_carry", {31'b0, bus.carry}, 32'h0);

      op(32'h1, 32'h2, 6'b001010);
      check("sub_1_2_result", bus.result, 32'hFFFFFFFF);
      check("sub_1_2_carry", {31'b0, bus.carry}, 32'h1);

      op(32'h5, 32'h3, 6'b001001);
      check("add_5_3_result", bus.result, 32'h00000008);
      check("add_5_3_carry", {31'b0, bus.carry}, 32'h0);

      op(32'hFFFFFFFF, 32'h1, 6'b001001);
      check("add_wrap_result", bus.result, 32'h0);
      check("add_wrap_carry", {31'b0, bus.carry}, 32'h1);

      op(32'h1234, 32'h1234, 6'b001010);
      check("sub_equal_result", bus.result, 32'h0);
      check("sub_equal_carry", {31'b0, bus.carry}, 32'h0);

      op(32'hF0F0_00FF, 32'h0FF0_0F0F, 6'b100100);
      check("and_result", bus.result, 32'h00F0000F);
      check("and_carry", {31'b0, bus.carry}, 32'h0);

      op(32'hF0F0_00FF, 32'h0FF0_0F0F, 6'b100101);
      check("or_result", bus.result, 32'hFFF00FFF);

      op(32'hF0F0_00FF, 32'h0FF0_0F0F, 6'b101010);
      check("sltu_false_result", bus.result, 32'h0);

      op(32'h0FF0_0F0F, 32'hF0F0_00FF, 6'b101010);
      check("sltu_true_result", bus.result, 32'h1);
      check("sltu_true_carry", {31'b0, bus.carry}, 32'h0);

      op(32'hFFFFFFFF, 32'h1, 6'b001001);
      op(32'hDEAD_BEEF, 32'h1234_5678, 6'b111111);
      check("bad_funct_result", bus.result, 32'h0);
      check("bad_funct_carry", {31'b0, bus.carry}, 32'h0);

`ifdef ALU_SHIFT_EN
      op(32'h1, 32'd31, 6'b000000);
      check("sll_31_result", bus.result, 32'h80000000);
      op(32'h80000000, 32'h21, 6'b000010);
      check("srl_21_result", bus.result, 32'h40000000);
`else
      op(32'h1, 32'd31, 6'b000000);
      check("sll_off_result", bus.result, 32'h0);
      op(32'h80000000, 32'h21, 6'b000010);
      check("srl_off_result", bus.result, 32'h0);
`endif

      // Asynchronous reset mid-cycle while outputs are all ones with carry set.
      op(32'h1, 32'h2, 6'b001010);
      check("pre_reset_result", bus.result, 32'hFFFFFFFF);
      check("pre_reset_carry", {31'b0, bus.carry}, 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_result", bus.result, 32'h0);
      check("async_reset_carry", {31'b0, bus.carry}, 32'h0);
      @(posedge clk);
      #1;
      check("held_reset_result", bus.result, 32'h0);
      check("held_reset_carry", {31'b0, bus.carry}, 32'h0);

      @(negedge clk);
      bus.src1  = 32'h5;
      bus.src2  = 32'h3;
      bus.funct = 6'b001001;
      rst_n     = 1'b1;
      @(posedge clk);
      #1;
      check("post_reset_result", bus.result, 32'h00000008);
      check("post_reset_carry", {31'b0, bus.carry}, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
